// File: rtl/change_dispenser_pkg.sv
// -----------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the change dispenser:
//   denom_t      - 2-bit denomination code (0=1, 1=5, 2=10, 3=50)
//   COIN_VAL_*   - face value of each denomination
//   state_t      - dispenser FSM states (IDLE, PROD, DISP, DONE)
//   coin_value() - maps a denomination code to its face value
// -----------------------------------------------------------------------------
package vending_pkg;

  localparam int NUM_DENOM = 4;

  typedef enum logic [1:0] {
    DEN_1  = 2'd0,
    DEN_5  = 2'd1,
    DEN_10 = 2'd2,
    DEN_50 = 2'd3
  } denom_t;

  localparam logic [7:0] COIN_VAL_1  = 8'd1;
  localparam logic [7:0] COIN_VAL_5  = 8'd5;
  localparam logic [7:0] COIN_VAL_10 = 8'd10;
  localparam logic [7:0] COIN_VAL_50 = 8'd50;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROD = 2'd1,
    DISP = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [7:0] coin_value(input denom_t code);
    logic [7:0] val;
    val = COIN_VAL_1;
    case (code)
      DEN_1:  val = COIN_VAL_1;
      DEN_5:  val = COIN_VAL_5;
      DEN_10: val = COIN_VAL_10;
      DEN_50: val = COIN_VAL_50;
      default: val = COIN_VAL_1;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// -----------------------------------------------------------------------------
// change_dispenser_if
// Bundles the request, coin-ejector, product-drop and status signals of the
// change dispenser.
//   master : upstream vending stage / ejector side (drives MO, PO, coin_ack,
//            refill; observes everything else)
//   slave  : the dispenser itself
// Signals:
//   MO[7:0]       change amount request      PO[1:0]     product code (0=none)
//   in_ready      dispenser idle             coin_out    denomination code
//   coin_valid    coin_out holds a coin      coin_ack    ejector took the coin
//   prod_out      product to drop            prod_valid  product drop command
//   done          end-of-transaction pulse   err_short   change incomplete pulse
//   refill        reload coin inventory
// -----------------------------------------------------------------------------
interface change_dispenser_if;

  logic [7:0] MO;
  logic [1:0] PO;
  logic       in_ready;
  logic [1:0] coin_out;
  logic       coin_valid;
  logic       coin_ack;
  logic [1:0] prod_out;
  logic       prod_valid;
  logic       done;
  logic       err_short;
  logic       refill;

  modport master (
    output MO, PO, coin_ack, refill,
    input  in_ready, coin_out, coin_valid, prod_out, prod_valid, done, err_short
  );

  modport slave (
    input  MO, PO, coin_ack, refill,
    output in_ready, coin_out, coin_valid, prod_out, prod_valid, done, err_short
  );

endinterface

// File: rtl/change_dispenser_coin_select.sv
// -----------------------------------------------------------------------------
// coin_select
// Purely combinational greedy denomination picker: returns the largest
// available denomination whose value does not exceed the remaining amount.
// Ports:
//   i_remaining[7:0] - amount still owed
//   i_avail[3:0]     - availability mask, bit index = denomination code
//   o_code           - selected denomination
//   o_valid          - a denomination could be selected
// -----------------------------------------------------------------------------
module coin_select
  import vending_pkg::*;
(
  input  logic [7:0] i_remaining,
  input  logic [3:0] i_avail,
  output denom_t     o_code,
  output logic       o_valid
);

  logic [3:0] w_fit;

  generate
    for (genvar gi = 0; gi < NUM_DENOM; gi++) begin : g_fit
      localparam logic [1:0] CODE = 2'(gi);
      assign w_fit[gi] = i_avail[gi] && (i_remaining >= coin_value(denom_t'(CODE)));
    end
  endgenerate

  // Highest denomination wins; remaining==0 never fits since every value >= 1.
  always_comb begin
    o_code  = DEN_1;
    o_valid = 1'b0;
    if (w_fit[3]) begin
      o_code  = DEN_50;
      o_valid = 1'b1;
    end else if (w_fit[2]) begin
      o_code  = DEN_10;
      o_valid = 1'b1;
    end else if (w_fit[1]) begin
      o_code  = DEN_5;
      o_valid = 1'b1;
    end else if (w_fit[0]) begin
      o_code  = DEN_1;
      o_valid = 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
// Accepts a (change amount, product) request, issues a one-cycle product drop
// command, then ejects coins greedily (50/10/5/1) with a valid/ack handshake,
// and finishes with a one-cycle done pulse.
// Parameters:
//   INIT_COINS - coins per denomination loaded at reset / refill
//   MAX_AMT    - largest accepted change amount; larger requests are clamped
// Ports:
//   clk - clock (rising edge)
//   rst - asynchronous active-high reset
//   bus - change_dispenser_if.slave (request, coin, product and status signals)
// Build option:
//   CHANGE_INVENTORY_EN - when defined, per-denomination coin counters limit
//                         availability, err_short reports incomplete change and
//                         refill (in IDLE only) reloads the counters. When not
//                         defined, every denomination is always available,
//                         err_short stays 0 and refill is ignored.
// -----------------------------------------------------------------------------
module change_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned INIT_COINS = 8,
  parameter int unsigned MAX_AMT    = 255
) (
  input  logic               clk,
  input  logic               rst,
  change_dispenser_if.slave  bus
);

  localparam logic [7:0] AMT_LIMIT = (MAX_AMT > 255) ? 8'd255 : 8'(MAX_AMT);

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_remaining;
  logic [1:0] r_prod;
  logic       r_short;

  logic [3:0] w_avail;
  denom_t     w_sel_code;
  logic       w_sel_valid;
  logic       w_start;
  logic [7:0] w_amt;
  logic       w_coin_valid;
  logic       w_ack;
  logic [7:0] w_coin_val;
  logic [7:0] w_rem_after;
  logic       w_stuck;

  assign w_start      = (r_state == IDLE) && ((bus.MO != 8'd0) || (bus.PO != 2'd0));
  assign w_amt        = (bus.MO > AMT_LIMIT) ? AMT_LIMIT : bus.MO;
  assign w_coin_valid = (r_state == DISP) && w_sel_valid;
  // coin_ack only counts while a coin is actually offered.
  assign w_ack        = w_coin_valid && bus.coin_ack;
  assign w_coin_val   = coin_value(w_sel_code);
  // Selected value never exceeds r_remaining, so this cannot wrap.
  assign w_rem_after  = r_remaining - w_coin_val;
  // Something still owed but nothing in stock can pay any part of it.
  assign w_stuck      = (r_state == DISP) && (r_remaining != 8'd0) && !w_sel_valid;

  coin_select u_coin_select (
    .i_remaining (r_remaining),
    .i_avail     (w_avail),
    .o_code      (w_sel_code),
    .o_valid     (w_sel_valid)
  );

`ifdef CHANGE_INVENTORY_EN
  localparam int CNT_W = (INIT_COINS < 2) ? 1 : $clog2(INIT_COINS + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_COINS);

  generate
    for (genvar gi = 0; gi < NUM_DENOM; gi++) begin : g_inv
      localparam logic [1:0] CODE = 2'(gi);
      logic [CNT_W-1:0] r_count;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_count <= CNT_INIT;
        end else if ((r_state == IDLE) && bus.refill) begin
          r_count <= CNT_INIT;
        end else if (w_ack && (w_sel_code == denom_t'(CODE))) begin
          r_count <= r_count - 1'b1;
        end
      end

      assign w_avail[gi] = (r_count != '0);
    end
  endgenerate
`else
  logic [1:0] w_unused;
  assign w_unused = {bus.refill, (INIT_COINS != 0)};
  assign w_avail  = 4'b1111;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_next = (bus.PO != 2'd0) ? PROD : DISP;
        end
      end
      PROD: w_state_next = DISP;
      DISP: begin
        if (r_remaining == 8'd0) begin
          w_state_next = DONE;
        end else if (!w_sel_valid) begin
          w_state_next = DONE;
        end else if (w_ack && (w_rem_after == 8'd0)) begin
          w_state_next = DONE;
        end
      end
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Transaction datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_remaining <= 8'd0;
      r_prod      <= 2'd0;
      r_short     <= 1'b0;
    end else begin
      if (w_start) begin
        r_remaining <= w_amt;
        r_prod      <= bus.PO;
        r_short     <= 1'b0;
      end else if (w_stuck) begin
        // Remainder is discarded; the shortfall is reported with done.
        r_remaining <= 8'd0;
        r_short     <= 1'b1;
      end else if (w_ack) begin
        r_remaining <= w_rem_after;
      end
    end
  end

  // Outputs
  always_comb begin
    bus.in_ready   = (r_state == IDLE);
    bus.prod_valid = (r_state == PROD);
    bus.prod_out   = (r_state == PROD) ? r_prod : 2'd0;
    bus.coin_valid = w_coin_valid;
    bus.coin_out   = w_coin_valid ? w_sel_code : 2'd0;
    bus.done       = (r_state == DONE);
    bus.err_short  = (r_state == DONE) && r_short;
  end

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
// Directed, self-checking bench for change_dispenser. Inputs are driven and
// outputs sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  change_dispenser_if bus ();

  change_dispenser #(
    .INIT_COINS (8),
    .MAX_AMT    (255)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef CHANGE_INVENTORY_EN
  change_dispenser_if bus2 ();

  change_dispenser #(
    .INIT_COINS (1),
    .MAX_AMT    (255)
  ) u_dut_inv (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_coins [5];
    exp_coins = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0};

    bus.MO       = 8'd0;
    bus.PO       = 2'd0;
    bus.coin_ack = 1'b0;
    bus.refill   = 1'b0;
`ifdef CHANGE_INVENTORY_EN
    bus2.MO       = 8'd0;
    bus2.PO       = 2'd0;
    bus2.coin_ack = 1'b0;
    bus2.refill   = 1'b0;
`endif

    // Reset state
    #1;
    chk("rst_in_ready",   32'(bus.in_ready),   32'd1);
    chk("rst_coin_valid", 32'(bus.coin_valid), 32'd0);
    chk("rst_prod_valid", 32'(bus.prod_valid), 32'd0);
    chk("rst_done",       32'(bus.done),       32'd0);
    chk("rst_err_short",  32'(bus.err_short),  32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // MO=67, PO=2, ack tied high
    $display("txn MO=67 PO=2 ack=always");
    bus.MO = 8'd67; bus.PO = 2'd2; bus.coin_ack = 1'b1;
    tick();
    bus.MO = 8'd0; bus.PO = 2'd0;
    chk("t1_prod_valid", 32'(bus.prod_valid), 32'd1);
    chk("t1_prod_out",   32'(bus.prod_out),   32'd2);
    chk("t1_in_ready",   32'(bus.in_ready),   32'd0);
    chk("t1_no_coin",    32'(bus.coin_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_coin_valid", 32'(bus.coin_valid), 32'd1);
      chk("t1_coin_out",   32'(bus.coin_out),   32'(exp_coins[i]));
      chk("t1_prod_off",   32'(bus.prod_valid), 32'd0);
    end
    tick();
    chk("t1_done",       32'(bus.done),       32'd1);
    chk("t1_err_short",  32'(bus.err_short),  32'd0);
    chk("t1_done_coin",  32'(bus.coin_valid), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(bus.done),       32'd0);
    chk("t1_idle",       32'(bus.in_ready),   32'd1);

    // MO=0, PO=0 for 10 cycles: nothing starts, stray ack ignored
    $display("txn MO=0 PO=0 idle x10");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_idle", 32'({bus.in_ready, bus.prod_valid, bus.coin_valid, bus.done}), 32'b1000);
    end
    bus.coin_ack = 1'b0;

    // Product only: no coin, done after the empty DISP cycle
    $display("txn MO=0 PO=1");
    bus.PO = 2'd1;
    tick();
    bus.PO = 2'd0;
    chk("t3_prod_valid", 32'(bus.prod_valid), 32'd1);
    chk("t3_prod_out",   32'(bus.prod_out),   32'd1);
    tick();
    chk("t3_no_coin",    32'(bus.coin_valid), 32'd0);
    tick();
    chk("t3_done",       32'(bus.done),       32'd1);
    tick();
    chk("t3_idle",       32'(bus.in_ready),   32'd1);

    // MO=15, PO=0, ack delayed 3 cycles per coin
    $display("txn MO=15 PO=0 ack delayed");
    bus.MO = 8'd15;
    tick();
    bus.MO = 8'd0;
    chk("t4_no_prod", 32'(bus.prod_valid), 32'd0);
    for (int c = 0; c < 2; c++) begin
      for (int w = 0; w < 3; w++) begin
        chk("t4_coin_valid", 32'(bus.coin_valid), 32'd1);
        chk("t4_coin_out",   32'(bus.coin_out),   (c == 0) ? 32'd2 : 32'd1);
        chk("t4_no_done",    32'(bus.done),       32'd0);
        if (w == 2) bus.coin_ack = 1'b1;
        tick();
        bus.coin_ack = 1'b0;
      end
    end
    chk("t4_done",      32'(bus.done),       32'd1);
    chk("t4_err_short", 32'(bus.err_short),  32'd0);
    tick();
    chk("t4_idle",      32'(bus.in_ready),   32'd1);

    // Reset mid-DISP with MO=100
    $display("txn MO=100 PO=0 reset mid-dispense");
    bus.MO = 8'd100;
    tick();
    bus.MO = 8'd0;
    chk("t5_coin_out", 32'(bus.coin_out), 32'd3);
    bus.coin_ack = 1'b1;
    tick();
    bus.coin_ack = 1'b0;
    chk("t5_second_coin", 32'({bus.coin_valid, bus.coin_out}), 32'b111);
    rst = 1'b1;
    #1;
    chk("t5_rst_coin_valid", 32'(bus.coin_valid), 32'd0);
    chk("t5_rst_coin_out",   32'(bus.coin_out),   32'd0);
    chk("t5_rst_in_ready",   32'(bus.in_ready),   32'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_done", 32'({bus.done, bus.in_ready}), 32'b01);
    end

    $display("txn MO=5 PO=0 after reset");
    bus.MO = 8'd5;
    tick();
    bus.MO = 8'd0;
    chk("t6_coin_valid", 32'(bus.coin_valid), 32'd1);
    chk("t6_coin_out",   32'(bus.coin_out),   32'd1);
    bus.coin_ack = 1'b1;
    tick();
    bus.coin_ack = 1'b0;
    chk("t6_done",       32'(bus.done),       32'd1);
    tick();
    chk("t6_idle",       32'(bus.in_ready),   32'd1);

`ifdef CHANGE_INVENTORY_EN
    // INIT_COINS=1, MO=70 -> 50,10,5,1 then short by 4
    $display("txn inv MO=70 PO=0 INIT_COINS=1");
    bus2.MO = 8'd70; bus2.coin_ack = 1'b1;
    tick();
    bus2.MO = 8'd0;
    for (int i = 0; i < 4; i++) begin
      chk("t7_coin_valid", 32'(bus2.coin_valid), 32'd1);
      chk("t7_coin_out",   32'(bus2.coin_out),   32'(3 - i));
      tick();
    end
    chk("t7_stuck_no_coin", 32'(bus2.coin_valid), 32'd0);
    tick();
    chk("t7_done",      32'(bus2.done),      32'd1);
    chk("t7_err_short", 32'(bus2.err_short), 32'd1);
    tick();
    chk("t7_err_pulse", 32'(bus2.err_short), 32'd0);

    $display("txn inv MO=1 before refill");
    bus2.MO = 8'd1;
    tick();
    bus2.MO = 8'd0;
    chk("t8_empty_no_coin", 32'(bus2.coin_valid), 32'd0);
    tick();
    chk("t8_short", 32'({bus2.done, bus2.err_short}), 32'b11);
    tick();

    $display("txn inv refill then MO=1");
    bus2.refill = 1'b1;
    tick();
    bus2.refill = 1'b0;
    bus2.MO = 8'd1;
    tick();
    bus2.MO = 8'd0;
    chk("t9_coin_valid", 32'(bus2.coin_valid), 32'd1);
    chk("t9_coin_out",   32'(bus2.coin_out),   32'd0);
    tick();
    chk("t9_done_ok", 32'({bus2.done, bus2.err_short}), 32'b10);
    bus2.coin_ack = 1'b0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter INIT_COINS, default 8, the per-denomination coin count loaded at reset or refill.
REQ-002 SHALL have parameter MAX_AMT, default 255, the largest accepted change amount; amounts above it SHALL be clamped to it.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port MO, input, 8 bits: change amount from the upstream vending stage.
REQ-006 SHALL have port PO, input, 2 bits: product code from the vending stage; 0 means no product.
REQ-007 SHALL have port in_ready, output, 1 bit: high when a new request can be accepted.
REQ-008 SHALL have port coin_out, output, 2 bits: denomination code, 0=1, 1=5, 2=10, 3=50.
REQ-009 SHALL have port coin_valid, output, 1 bit: coin_out holds a coin to eject.
REQ-010 SHALL have port coin_ack, input, 1 bit: ejector accepted the coin.
REQ-011 SHALL have port prod_out, output, 2 bits, and port prod_valid, output, 1 bit: product drop command.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a transaction.
REQ-013 SHALL have port err_short, output, 1 bit: one-cycle pulse when change could not be completed.
REQ-014 SHALL have port refill, input, 1 bit: reloads the inventory (see REQ-028).

Function
REQ-015 SHALL implement FSM states IDLE, PROD, DISP and DONE.
REQ-016 SHALL assert in_ready only in IDLE.
REQ-017 SHALL start a request in IDLE when (MO!=0 || PO!=0); MO==0 && PO==0 SHALL NOT start a transaction.
REQ-018 On start, SHALL latch MO into an 8-bit remaining register and PO into a product register.
REQ-019 From IDLE, SHALL go to PROD if PO!=0, else to DISP.
REQ-020 In PROD, SHALL assert prod_valid with prod_out equal to the latched PO for exactly one cycle, then go to DISP.
REQ-021 On entering DISP with remaining==0, SHALL go to DONE with no coin issued.
REQ-022 In DISP, SHALL select the largest available denomination not exceeding remaining, hold coin_valid and coin_out stable until coin_ack, and on ack subtract that value from remaining.
REQ-023 SHALL ignore coin_ack when coin_valid is low; remaining SHALL never underflow.
REQ-024 On the ack that makes remaining 0, SHALL go to DONE; DONE SHALL pulse done for one cycle, then return to IDLE.
REQ-025 If remaining>0 and no denomination is selectable, SHALL go to DONE with err_short asserted in the same cycle as done, discarding the remainder.
REQ-026 Latency, with accept at edge N: prod_valid SHALL be high in cycle N+1; the first coin_valid SHALL be high in cycle N+2 (N+1 if PO==0).

Reset
REQ-027 While rst is high, SHALL force state IDLE, remaining 0, and all outputs 0 except in_ready=1, and set inventory to INIT_COINS; a transaction interrupted by reset SHALL be abandoned with no done.

Configuration
REQ-028 With CHANGE_INVENTORY_EN defined:
- SHALL keep four inventory counters; a denomination is available only if its count>0.
- SHALL decrement a counter on each acked coin of that denomination.
- A refill in IDLE SHALL reload all counters to INIT_COINS; refill outside IDLE SHALL be ignored.
REQ-029 Without CHANGE_INVENTORY_EN, SHALL treat every denomination as always available, SHALL hold err_short at 0, and SHALL ignore refill.

Structure
REQ-030 SHALL declare the denomination code typedef, the coin value constants (1/5/10/50) and the FSM state typedef in the shared package vending_pkg.
REQ-031 SHALL place denomination selection in sub-module coin_select (inputs: remaining, availability mask; output: code plus valid), which is purely combinational.

Verification
REQ-032 MO=67, PO=2, coin_ack tied high -> prod_valid with prod_out=2 in cycle N+1, coins 3,2,1,0,0 in cycles N+2..N+6, done in N+7.
REQ-033 MO=0, PO=0 for 10 cycles -> in_ready stays 1; no prod_valid, coin_valid or done.
REQ-034 MO=15, PO=0, coin_ack delayed 3 cycles per coin -> coin_out=2 stays stable until ack, then 1; done after the second ack.
REQ-035 CHANGE_INVENTORY_EN, INIT_COINS=1, MO=70 -> coins 3,2,1,0, then err_short together with done (4 undispensed); refill restores the counters.
REQ-036 rst asserted mid-DISP with MO=100 -> outputs cleared immediately and in_ready=1; no done; the next request MO=5 is dispensed normally.
